// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache sitting between the fetch port
// and the memory controller. Hits are combinational; a miss fetches one word and fills.
module icache #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              inv,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = WORD_W - IW - 2;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t state, nextState;

  logic [SETS-1:0]   frameValid;
  logic [TW-1:0]     frameTag  [SETS];
  logic [WORD_W-1:0] frameData [SETS];

  logic [WORD_W-1:0] missAddr;
  logic [31:0]       hitCount;
  logic [31:0]       missCount;

  logic [IW-1:0] reqIdx;
  logic [TW-1:0] reqTag;
  logic [IW-1:0] fillIdx;
  logic [TW-1:0] fillTag;
  logic          tagHit;
  logic          issueMiss;
  logic          fillDone;
  logic          unusedOffset;

  assign reqIdx       = imemaddr[IW+1:2];
  assign reqTag       = imemaddr[WORD_W-1:IW+2];
  assign fillIdx      = missAddr[IW+1:2];
  assign fillTag      = missAddr[WORD_W-1:IW+2];
  assign unusedOffset = ^imemaddr[1:0];

  assign tagHit = imemREN && frameValid[reqIdx] && (frameTag[reqIdx] == reqTag);

  // Next-state and outputs; an invalidate in IDLE suppresses both hit and miss.
  always_comb begin
    nextState = state;
    ihit      = 1'b0;
    imemload  = '0;
    iREN      = 1'b0;
    iaddr     = '0;
    issueMiss = 1'b0;
    fillDone  = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          imemload = frameData[reqIdx];
          if (!inv) begin
            if (tagHit) begin
              ihit = 1'b1;
            end else begin
              issueMiss = 1'b1;
              nextState = FETCH;
            end
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = missAddr;
        if (!iwait) begin
          fillDone  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      missAddr <= '0;
    end else begin
      state <= nextState;
      if (issueMiss) begin
        missAddr <= {imemaddr[WORD_W-1:2], 2'b00};
      end
    end
  end

  // The controller cannot cancel a read, so a fill always lands unless inv discards it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      frameValid <= '0;
      for (int i = 0; i < SETS; i++) begin
        frameTag[i]  <= '0;
        frameData[i] <= '0;
      end
    end else begin
      if (inv) begin
        frameValid <= '0;
      end else if (fillDone) begin
        frameValid[fillIdx] <= 1'b1;
        frameTag[fillIdx]   <= fillTag;
        frameData[fillIdx]  <= iload;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (ihit && imemREN && (hitCount != 32'hFFFF_FFFF)) begin
        hitCount <= hitCount + 32'd1;
      end
      if (issueMiss && (missCount != 32'hFFFF_FFFF)) begin
        missCount <= missCount + 32'd1;
      end
    end
  end

  assign hit_count  = hitCount;
  assign miss_count = missCount;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random fetch traffic,
// all compared against a line-level reference model of a direct-mapped cache.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        inv;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int compared;
  int mismatched;

  // Reference model: each of the 16 lines remembers the word address it holds.
  bit          mValid [16];
  logic [29:0] mWord  [16];
  logic [31:0] mData  [16];
  bit          mBusy;
  logic [31:0] mPending;
  logic [31:0] mHits;
  logic [31:0] mMisses;

  icache #(.SETS(16), .WORD_W(32)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .inv(inv),
    .ihit(ihit),
    .imemload(imemload),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit modelHit();
    int i;
    i = int'(imemaddr[5:2]);
    return !mBusy && imemREN && !inv && mValid[i] && (mWord[i] == imemaddr[31:2]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mWord[i]  = '0;
      mData[i]  = '0;
    end
    mBusy    = 1'b0;
    mPending = '0;
    mHits    = '0;
    mMisses  = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit wasBusy;
    bit hitNow;
    int f;
    wasBusy = mBusy;
    hitNow  = modelHit();
    if (!wasBusy) begin
      if (hitNow) begin
        if (mHits != 32'hFFFF_FFFF) mHits = mHits + 1;
      end else if (imemREN && !inv) begin
        if (mMisses != 32'hFFFF_FFFF) mMisses = mMisses + 1;
        mBusy    = 1'b1;
        mPending = {imemaddr[31:2], 2'b00};
      end
    end
    if (inv) begin
      for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    end
    if (wasBusy && !iwait) begin
      mBusy = 1'b0;
      if (!inv) begin
        f         = int'(mPending[5:2]);
        mValid[f] = 1'b1;
        mWord[f]  = mPending[31:2];
        mData[f]  = iload;
      end
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit          expHit;
    logic [31:0] expLoad;
    expHit  = modelHit();
    expLoad = expHit ? mData[int'(imemaddr[5:2])] : 32'h0;
    compare({tag, ".ihit"}, {31'b0, ihit}, {31'b0, expHit});
    compare({tag, ".iREN"}, {31'b0, iREN}, {31'b0, mBusy});
    compare({tag, ".iaddr"}, iaddr, mBusy ? mPending : 32'h0);
    if (mBusy || !imemREN || expHit) begin
      compare({tag, ".imemload"}, imemload, expLoad);
    end
    compare({tag, ".hit_count"}, hit_count, mHits);
    compare({tag, ".miss_count"}, miss_count, mMisses);
  endtask

  task automatic applyStimulus(input bit ren, input logic [31:0] addr, input bit invIn,
                               input bit waitIn, input logic [31:0] load, input string tag);
    @(negedge CLK);
    imemREN  = ren;
    imemaddr = addr;
    inv      = invIn;
    iwait    = waitIn;
    iload    = load;
    #1 checkOutput(tag);
    @(posedge CLK);
    modelStep();
  endtask

  task automatic cyc(input bit ren, input logic [31:0] addr, input bit invIn,
                     input bit waitIn, input string tag);
    applyStimulus(ren, addr, invIn, waitIn, memWord(mPending), tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    inv      = 1'b0;
    iwait    = 1'b1;
    iload    = '0;
    modelReset();
    @(negedge CLK);
    #1 checkOutput("reset");
    @(negedge CLK);
    nRST = 1'b1;

    $display("[TB] cold miss");
    for (int k = 0; k < 4; k++) applyStimulus(1, 32'h40, 0, 1, 32'h2001_000A, "cold");
    applyStimulus(1, 32'h40, 0, 0, 32'h2001_000A, "cold_fill");
    applyStimulus(1, 32'h40, 0, 1, 32'h0, "cold_hit");
    compare("cold_data", mData[0], 32'h2001_000A);

    $display("[TB] hit with offset bits");
    for (int k = 0; k < 3; k++) applyStimulus(1, 32'h42, 0, 1, 32'h0, "offset_hit");

    $display("[TB] conflict");
    cyc(1, 32'h80, 0, 1, "conf_miss");
    cyc(1, 32'h80, 0, 0, "conf_fill");
    cyc(1, 32'h80, 0, 1, "conf_hit");
    cyc(1, 32'h40, 0, 1, "conf_remiss");
    cyc(1, 32'h40, 0, 0, "conf_refill");
    cyc(1, 32'h40, 0, 1, "conf_rehit");
    compare("conf_misses", miss_count, 32'd3);

    $display("[TB] abandon during fetch");
    cyc(1, 32'h100, 0, 1, "aband_miss");
    cyc(0, 32'h1FC, 0, 1, "aband_drop");
    cyc(1, 32'h3C, 0, 1, "aband_move");
    cyc(0, 32'h8, 0, 0, "aband_fill");
    cyc(1, 32'h100, 0, 1, "aband_hit");

    $display("[TB] invalidate");
    for (int k = 1; k < 4; k++) begin
      cyc(1, 32'h40 + 32'(4 * k), 0, 1, "inv_miss");
      cyc(1, 32'h40 + 32'(4 * k), 0, 0, "inv_fill");
    end
    cyc(1, 32'h44, 1, 1, "inv_pulse");
    cyc(1, 32'h44, 0, 1, "inv_after_miss");
    cyc(1, 32'h44, 1, 0, "inv_on_fill");
    cyc(1, 32'h44, 0, 1, "inv_discard_miss");
    cyc(1, 32'h44, 0, 0, "inv_refill");
    cyc(1, 32'h100, 0, 1, "inv_old_miss");
    cyc(1, 32'h100, 0, 0, "inv_old_fill");

    $display("[TB] async reset during fetch");
    cyc(1, 32'h48, 0, 1, "rst_miss");
    #2;
    imemREN = 1'b0;
    nRST    = 1'b0;
    modelReset();
    #1 checkOutput("rst_async");
    compare("rst_iren", {31'b0, iREN}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    cyc(1, 32'h44, 0, 1, "rst_cold_miss");
    cyc(1, 32'h44, 0, 0, "rst_cold_fill");

    $display("[TB] random traffic");
    for (int k = 0; k < 800; k++) begin
      logic [31:0] addr;
      addr = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
      cyc(($urandom % 4) != 0, addr, ($urandom % 40) == 0, ($urandom % 2) == 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
